// File: rtl/lab2_serial_sub_if.sv
// lab2_serial_sub_if: start/operand/result bundle for the bit-serial subtractor
interface lab2_serial_sub_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow_out;
  modport master(output start, a, b, input busy, done, diff, borrow_out);
  modport slave(input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/lab2_serial_sub.sv
// lab2_serial_sub: computes a - b LSB first through one full-subtractor cell over WIDTH cycles
module lab2_serial_sub #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  lab2_serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, diff_q;
  logic [CW-1:0] cnt;
  logic br, bo_q, x, y, d, bout, accept, last;
  assign accept = bus.start && state != RUN;
  assign last = cnt == CW'(WIDTH - 1);
  assign x = sa[0];
  assign y = sb[0];
  assign d = x ^ y ^ br;
  assign bout = (~x & y) | (~(x ^ y) & br);
  assign bus.diff = diff_q;
  assign bus.borrow_out = bo_q;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: a start outside RUN always wins, so DONE can chain straight into RUN
  always_comb
    state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  // handshake outputs decoded from the state register only
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
  end
  // operand shifters, borrow flop, counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff_q <= '0;
      bo_q <= 1'b0;
    end else if (accept) begin
      sa <= bus.a;
      sb <= bus.b;
      br <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      diff_q <= {d, diff_q[WIDTH-1:1]};
      br <= bout;
      cnt <= cnt + 1'b1;
      if (last) bo_q <= bout;
    end
  end
endmodule

// File: tb/tb_lab2_serial_sub.sv
// tb_lab2_serial_sub: scoreboard bench for the bit-serial subtractor at WIDTH 8 and 2
module tb_lab2_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lab2_serial_sub_if #(.WIDTH(8)) b8();
  lab2_serial_sub_if #(.WIDTH(2)) b2();
  lab2_serial_sub #(.WIDTH(8)) u8(.clk(clk), .rst(rst), .bus(b8.slave));
  lab2_serial_sub #(.WIDTH(2)) u2(.clk(clk), .rst(rst), .bus(b2.slave));
  typedef struct {logic [7:0] d; logic bo;} exp_t;
  exp_t q8[$];
  exp_t q2[$];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.d = a - b;
    e.bo = a < b;
    q8.push_back(e);
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b8.done && cyc < 20);
  endtask

  task automatic wait_done2(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b2.done && cyc < 10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp += 4;
    if (b8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", b8.busy); end
    if (b8.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", b8.done); end
    if (b8.diff !== 8'h00) begin n_bad++; $display("FAIL reset_diff got %h want 00", b8.diff); end
    if (b8.borrow_out !== 1'b0) begin n_bad++; $display("FAIL reset_borrow got %b want 0", b8.borrow_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_arith;
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    exp_t e;
    int cyc;
    ta = '{8'h35, 8'h12, 8'h00, 8'hFF};
    tb = '{8'h12, 8'h35, 8'h01, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      b8.start = 1'b1;
      b8.a = ta[i];
      b8.b = tb[i];
      push8(ta[i], tb[i]);
      tick();
      b8.start = 1'b0;
      n_cmp++;
      if (b8.busy !== 1'b1) begin n_bad++; $display("FAIL arith_busy[%0d] got %b want 1", i, b8.busy); end
      wait_done8(cyc);
      n_cmp++;
      if (cyc !== 8) begin n_bad++; $display("FAIL arith_latency[%0d] got %0d want 8", i, cyc); end
      n_cmp++;
      if (b8.busy !== 1'b0) begin n_bad++; $display("FAIL arith_busy_done[%0d] got %b want 0", i, b8.busy); end
      e = q8.pop_front();
      n_cmp += 2;
      if (b8.diff !== e.d) begin n_bad++; $display("FAIL arith_diff[%0d] got %h want %h", i, b8.diff, e.d); end
      if (b8.borrow_out !== e.bo) begin n_bad++; $display("FAIL arith_borrow[%0d] got %b want %b", i, b8.borrow_out, e.bo); end
      tick();
      n_cmp++;
      if (b8.done !== 1'b0) begin n_bad++; $display("FAIL arith_done_pulse[%0d] got %b want 0", i, b8.done); end
    end
  endtask

  task automatic test_exhaustive_w2;
    exp_t e;
    int cyc;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        b2.start = 1'b1;
        b2.a = 2'(a);
        b2.b = 2'(b);
        e.d = 8'((a - b) & 3);
        e.bo = a < b;
        q2.push_back(e);
        tick();
        b2.start = 1'b0;
        wait_done2(cyc);
        n_cmp++;
        if (cyc !== 2) begin n_bad++; $display("FAIL w2_latency a=%0d b=%0d got %0d want 2", a, b, cyc); end
        e = q2.pop_front();
        n_cmp += 2;
        if (b2.diff !== e.d[1:0]) begin n_bad++; $display("FAIL w2_diff a=%0d b=%0d got %0d want %0d", a, b, b2.diff, e.d[1:0]); end
        if (b2.borrow_out !== e.bo) begin n_bad++; $display("FAIL w2_borrow a=%0d b=%0d got %b want %b", a, b, b2.borrow_out, e.bo); end
        tick();
      end
    end
  endtask

  task automatic test_start_while_busy;
    exp_t e;
    int cyc;
    b8.start = 1'b1;
    b8.a = 8'h35;
    b8.b = 8'h12;
    push8(8'h35, 8'h12);
    tick();
    b8.start = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 2) begin
        b8.start = 1'b1;
        b8.a = 8'hFF;
        b8.b = 8'h00;
      end
      if (cyc == 3) b8.start = 1'b0;
    end while (!b8.done && cyc < 20);
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL busy_start_latency got %0d want 8", cyc); end
    e = q8.pop_front();
    n_cmp += 2;
    if (b8.diff !== e.d) begin n_bad++; $display("FAIL busy_start_diff got %h want %h", b8.diff, e.d); end
    if (b8.borrow_out !== e.bo) begin n_bad++; $display("FAIL busy_start_borrow got %b want %b", b8.borrow_out, e.bo); end
    tick();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc;
    int cyc2;
    int dbl;
    logic prev;
    b8.start = 1'b1;
    b8.a = 8'h35;
    b8.b = 8'h12;
    push8(8'h35, 8'h12);
    tick();
    cyc = 0;
    dbl = 0;
    prev = 1'b0;
    do begin
      tick();
      cyc++;
      if (prev && b8.done) dbl++;
      prev = b8.done;
    end while (!b8.done && cyc < 20);
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 8", cyc); end
    e = q8.pop_front();
    n_cmp += 2;
    if (b8.diff !== e.d) begin n_bad++; $display("FAIL b2b_first_diff got %h want %h", b8.diff, e.d); end
    if (b8.borrow_out !== e.bo) begin n_bad++; $display("FAIL b2b_first_borrow got %b want %b", b8.borrow_out, e.bo); end
    b8.a = 8'h12;
    b8.b = 8'h35;
    push8(8'h12, 8'h35);
    tick();
    b8.start = 1'b0;
    n_cmp += 2;
    if (b8.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_no_idle got busy=%b want 1", b8.busy); end
    if (b8.done !== 1'b0) begin n_bad++; $display("FAIL b2b_double_done got %b want 0", b8.done); end
    wait_done8(cyc2);
    n_cmp++;
    if (cyc2 + 1 !== 9) begin n_bad++; $display("FAIL b2b_gap got %0d want 9", cyc2 + 1); end
    e = q8.pop_front();
    n_cmp += 2;
    if (b8.diff !== e.d) begin n_bad++; $display("FAIL b2b_second_diff got %h want %h", b8.diff, e.d); end
    if (b8.borrow_out !== e.bo) begin n_bad++; $display("FAIL b2b_second_borrow got %b want %b", b8.borrow_out, e.bo); end
    tick();
    n_cmp += 2;
    if (b8.done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_after got %b want 0", b8.done); end
    if (dbl !== 0) begin n_bad++; $display("FAIL b2b_consecutive_done got %0d want 0", dbl); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int cyc;
    int seen;
    b8.start = 1'b1;
    b8.a = 8'h35;
    b8.b = 8'h12;
    tick();
    b8.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 4;
    if (b8.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", b8.busy); end
    if (b8.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", b8.done); end
    if (b8.diff !== 8'h00) begin n_bad++; $display("FAIL midrst_diff got %h want 00", b8.diff); end
    if (b8.borrow_out !== 1'b0) begin n_bad++; $display("FAIL midrst_borrow got %b want 0", b8.borrow_out); end
    seen = 0;
    repeat (12) begin
      tick();
      if (b8.done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midrst_spurious_done got %0d want 0", seen); end
    b8.start = 1'b1;
    b8.a = 8'h10;
    b8.b = 8'h01;
    push8(8'h10, 8'h01);
    tick();
    b8.start = 1'b0;
    wait_done8(cyc);
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("FAIL midrst_latency got %0d want 8", cyc); end
    e = q8.pop_front();
    n_cmp += 2;
    if (b8.diff !== e.d) begin n_bad++; $display("FAIL midrst_diff_after got %h want %h", b8.diff, e.d); end
    if (b8.borrow_out !== e.bo) begin n_bad++; $display("FAIL midrst_borrow_after got %b want %b", b8.borrow_out, e.bo); end
    tick();
  endtask

  initial begin
    b8.start = 1'b0;
    b8.a = '0;
    b8.b = '0;
    b2.start = 1'b0;
    b2.a = '0;
    b2.b = '0;
    test_reset();
    test_arith();
    test_exhaustive_w2();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (q8.size() + q2.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", q8.size() + q2.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
